i2c_target_burst: RTL and testbench

Parametrised successor to the bridge's single-byte I2C slave: a clock-oversampled I2C target supporting multi-byte write and read bursts, repeated START, and master ACK/NACK termination. Lives in the I2C domain of the SPI-to-I2C bridge. The TX side is fed from the async FIFO read port and the RX side feeds a downstream byte sink. It runs on i2c_clk only; SCL/SDA are plain inputs, and SDA is driven open-drain via an output enable.

---
 rtl/i2c_target_burst.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_target_burst.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_burst.sv
// Oversampled I2C target with multi-byte write/read bursts and repeated START.
// SCL/SDA are synchronised into i2c_clk; SDA is driven open-drain through sda_oe.
module i2c_target_burst #(
    parameter int                  DATA_WIDTH     = 8,
    parameter logic [6:0]          SLAVE_ADDR     = 7'h25,
    parameter int                  SYNC_STAGES    = 2,
    parameter logic [DATA_WIDTH-1:0] UNDERFLOW_BYTE = 8'hFF
) (
    input  logic                  i2c_clk,
    input  logic                  i2c_rst_n,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  addr_hit,
    output logic                  tx_underflow,
    output logic                  rx_overflow
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_scl_sync;
    logic [SYNC_STAGES-1:0]  r_sda_sync;
    logic                    r_scl_d;
    logic                    r_sda_d;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [2:0]              r_bit_cnt;
    logic                    r_rw;
    logic                    r_ack_phase;
    logic                    r_byte_done;
    logic                    r_rx_pend;

    logic                    w_scl;
    logic                    w_sda;
    logic                    w_rise;
    logic                    w_fall;
    logic                    w_start;
    logic                    w_stop;
    logic                    w_last;
    logic [DATA_WIDTH-1:0]   w_byte;
    logic [DATA_WIDTH-1:0]   w_load;

    assign w_scl   = r_scl_sync[SYNC_STAGES-1];
    assign w_sda   = r_sda_sync[SYNC_STAGES-1];
    assign w_rise  = w_scl & ~r_scl_d;
    assign w_fall  = ~w_scl & r_scl_d;
    assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_last  = (r_bit_cnt == 3'd7);
    assign w_byte  = {r_shift[DATA_WIDTH-2:0], w_sda};
    assign w_load  = tx_valid ? tx_data : UNDERFLOW_BYTE;

    // Idle bus is high on both lines, so the chain presets to 1.
    always_ff @(posedge i2c_clk or negedge i2c_rst_n) begin
        if (!i2c_rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    always_ff @(posedge i2c_clk or negedge i2c_rst_n) begin
        if (!i2c_rst_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= 3'd0;
            r_rw         <= 1'b0;
            r_ack_phase  <= 1'b0;
            r_byte_done  <= 1'b0;
            r_rx_pend    <= 1'b0;
            sda_oe       <= 1'b0;
            tx_ready     <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            busy         <= 1'b0;
            addr_hit     <= 1'b0;
            tx_underflow <= 1'b0;
            rx_overflow  <= 1'b0;
        end else begin
            tx_ready     <= 1'b0;
            addr_hit     <= 1'b0;
            tx_underflow <= 1'b0;
            rx_overflow  <= 1'b0;
            rx_valid     <= r_rx_pend;
            r_rx_pend    <= 1'b0;
            if (w_start) begin
                r_state     <= ADDR;
                r_bit_cnt   <= 3'd0;
                sda_oe      <= 1'b0;
                r_ack_phase <= 1'b0;
                r_byte_done <= 1'b0;
            end else if (w_stop) begin
                r_state     <= IDLE;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
                r_ack_phase <= 1'b0;
                r_byte_done <= 1'b0;
            end else begin
                unique case (r_state)
                    ADDR: if (w_rise) begin
                        r_shift <= w_byte;
                        if (w_last) begin
                            r_bit_cnt <= 3'd0;
                            if (w_byte[7:1] == SLAVE_ADDR) begin
                                addr_hit <= 1'b1;
                                busy     <= 1'b1;
                                r_rw     <= w_byte[0];
                                r_state  <= ADDR_ACK;
                            end else begin
                                r_state  <= IGNORE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    ADDR_ACK: if (w_fall) begin
                        if (!r_ack_phase) begin
                            sda_oe      <= 1'b1;
                            r_ack_phase <= 1'b1;
                        end else begin
                            r_ack_phase <= 1'b0;
                            if (r_rw) begin
                                r_shift      <= w_load;
                                sda_oe       <= ~w_load[DATA_WIDTH-1];
                                tx_ready     <= tx_valid;
                                tx_underflow <= ~tx_valid;
                                r_state      <= RD_DATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                r_state <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: if (w_rise) begin
                        r_shift <= w_byte;
                        if (w_last) begin
                            r_bit_cnt <= 3'd0;
                            if (rx_ready) begin
                                rx_data   <= w_byte;
                                r_rx_pend <= 1'b1;
                                r_state   <= WR_ACK;
                            end else begin
                                rx_overflow <= 1'b1;
                                r_state     <= IGNORE;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    WR_ACK: if (w_fall) begin
                        if (!r_ack_phase) begin
                            sda_oe      <= 1'b1;
                            r_ack_phase <= 1'b1;
                        end else begin
                            sda_oe      <= 1'b0;
                            r_ack_phase <= 1'b0;
                            r_bit_cnt   <= 3'd0;
                            r_state     <= WR_DATA;
                        end
                    end
                    // MSB is already on the wire at entry; each fall presents the next bit.
                    RD_DATA: begin
                        if (w_rise) begin
                            r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                            if (w_last) r_byte_done <= 1'b1;
                            else r_bit_cnt <= r_bit_cnt + 3'd1;
                        end else if (w_fall) begin
                            if (r_byte_done) begin
                                sda_oe      <= 1'b0;
                                r_byte_done <= 1'b0;
                                r_bit_cnt   <= 3'd0;
                                r_state     <= RD_ACK;
                            end else begin
                                sda_oe <= ~r_shift[DATA_WIDTH-1];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (w_rise) begin
                            if (w_sda) r_state <= IGNORE;
                            else r_ack_phase <= 1'b1;
                        end else if (w_fall && r_ack_phase) begin
                            r_ack_phase  <= 1'b0;
                            r_shift      <= w_load;
                            sda_oe       <= ~w_load[DATA_WIDTH-1];
                            tx_ready     <= tx_valid;
                            tx_underflow <= ~tx_valid;
                            r_bit_cnt    <= 3'd0;
                            r_state      <= RD_DATA;
                        end
                    end
                    IDLE, IGNORE: sda_oe <= 1'b0;
                    default:      r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_burst.sv
// Directed bench for i2c_target_burst: bus-level master model plus
// scoreboards for received bytes and bytes returned on reads.
module tb_i2c_target_burst;

    logic       i2c_clk = 1'b0;
    logic       i2c_rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       busy;
    logic       addr_hit;
    logic       tx_underflow;
    logic       rx_overflow;
    wire        sda_bus = m_sda & ~sda_oe;

    int checks = 0;
    int failures = 0;
    int hit_cnt = 0, rxv_cnt = 0, txr_cnt = 0;
    int unf_cnt = 0, ovf_cnt = 0, oe_cnt = 0, bfall_cnt = 0;
    logic prev_busy = 1'b0;

    logic [7:0] fifo[$];
    logic [7:0] exp_rd[$];
    logic [7:0] exp_rx[$];

    i2c_target_burst dut (
        .i2c_clk      (i2c_clk),
        .i2c_rst_n    (i2c_rst_n),
        .scl_in       (m_scl),
        .sda_in       (sda_bus),
        .sda_oe       (sda_oe),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .busy         (busy),
        .addr_hit     (addr_hit),
        .tx_underflow (tx_underflow),
        .rx_overflow  (rx_overflow)
    );

    always #5 i2c_clk = ~i2c_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge i2c_clk) begin
        logic [7:0] e;
        if (i2c_rst_n) begin
            if (tx_ready && fifo.size() != 0) e = fifo.pop_front();
            if (rx_valid) begin
                rxv_cnt++;
                check("rx_q_nonempty", 32'(exp_rx.size() != 0), 32'd1);
                if (exp_rx.size() != 0) begin
                    e = exp_rx.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e));
                end
            end
            if (addr_hit) hit_cnt++;
            if (tx_ready) txr_cnt++;
            if (tx_underflow) unf_cnt++;
            if (rx_overflow) ovf_cnt++;
            if (sda_oe) oe_cnt++;
            if (prev_busy && !busy) bfall_cnt++;
            prev_busy = busy;
        end
        tx_valid = (fifo.size() != 0);
        tx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i2c_clk);
        #1;
    endtask

    task automatic sbit(input logic b, output logic s);
        m_sda = b;
        tick(6);
        m_scl = 1'b1;
        tick(4);
        s = sda_bus;
        tick(4);
        m_scl = 1'b0;
        tick(2);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        tick(4);
        m_scl = 1'b1;
        tick(8);
        m_sda = 1'b0;
        tick(8);
        m_scl = 1'b0;
        tick(4);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        tick(6);
        m_scl = 1'b1;
        tick(6);
        m_sda = 1'b1;
        tick(8);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) sbit(b[i], s);
        sbit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) sbit(1'b1, d[i]);
        sbit(nack, s);
    endtask

    initial begin
        int h0, r0, t0, u0, o0, oe0, b0;
        logic ack;
        logic s;
        logic [7:0] d;

        tick(5);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_addr_hit", 32'(addr_hit), 32'd0);
        i2c_rst_n = 1'b1;
        tick(5);

        // Write burst
        h0 = hit_cnt; r0 = rxv_cnt; b0 = bfall_cnt;
        i2c_start();
        write_byte(8'h4A, ack);
        check("wr_addr_ack", 32'(ack), 32'd0);
        check("wr_busy", 32'(busy), 32'd1);
        exp_rx.push_back(8'h11);
        write_byte(8'h11, ack);
        check("wr_ack_11", 32'(ack), 32'd0);
        exp_rx.push_back(8'h22);
        write_byte(8'h22, ack);
        check("wr_ack_22", 32'(ack), 32'd0);
        exp_rx.push_back(8'h33);
        write_byte(8'h33, ack);
        check("wr_ack_33", 32'(ack), 32'd0);
        i2c_stop();
        check("wr_busy_stop", 32'(busy), 32'd0);
        check("wr_hits", 32'(hit_cnt - h0), 32'd1);
        check("wr_rx_count", 32'(rxv_cnt - r0), 32'd3);
        check("wr_rx_left", 32'(exp_rx.size()), 32'd0);
        check("wr_busy_falls", 32'(bfall_cnt - b0), 32'd1);

        // Read burst; A3 stays in the FIFO after the NACK
        t0 = txr_cnt;
        fifo.push_back(8'hA0); exp_rd.push_back(8'hA0);
        fifo.push_back(8'hA1); exp_rd.push_back(8'hA1);
        fifo.push_back(8'hA2); exp_rd.push_back(8'hA2);
        fifo.push_back(8'hA3);
        tick(3);
        i2c_start();
        write_byte(8'h4B, ack);
        check("rd_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b0, d);
        check("rd_byte0", 32'(d), 32'(exp_rd.pop_front()));
        read_byte(1'b0, d);
        check("rd_byte1", 32'(d), 32'(exp_rd.pop_front()));
        read_byte(1'b1, d);
        check("rd_byte2", 32'(d), 32'(exp_rd.pop_front()));
        tick(4);
        check("rd_no_drive_after_nack", 32'(sda_oe), 32'd0);
        i2c_stop();
        check("rd_tx_ready_count", 32'(txr_cnt - t0), 32'd3);
        check("rd_fifo_left", 32'(fifo.size()), 32'd1);
        fifo.delete();
        tick(3);

        // Address mismatch
        h0 = hit_cnt; oe0 = oe_cnt; r0 = rxv_cnt;
        i2c_start();
        write_byte(8'h50, ack);
        check("mis_nack", 32'(ack), 32'd1);
        check("mis_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
        check("mis_busy", 32'(busy), 32'd0);
        write_byte(8'h4A, ack);
        check("mis_ignored_nack", 32'(ack), 32'd1);
        i2c_stop();
        check("mis_hits", 32'(hit_cnt - h0), 32'd0);
        check("mis_rx", 32'(rxv_cnt - r0), 32'd0);

        // Repeated START: write then read
        h0 = hit_cnt; b0 = bfall_cnt;
        i2c_start();
        write_byte(8'h4A, ack);
        check("rs_wr_addr_ack", 32'(ack), 32'd0);
        exp_rx.push_back(8'h05);
        write_byte(8'h05, ack);
        check("rs_ack_05", 32'(ack), 32'd0);
        fifo.push_back(8'hC3); exp_rd.push_back(8'hC3);
        i2c_start();
        check("rs_busy_held", 32'(busy), 32'd1);
        write_byte(8'h4B, ack);
        check("rs_rd_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b1, d);
        check("rs_rd_byte", 32'(d), 32'(exp_rd.pop_front()));
        check("rs_busy_before_stop", 32'(busy), 32'd1);
        i2c_stop();
        check("rs_busy_stop", 32'(busy), 32'd0);
        check("rs_busy_falls", 32'(bfall_cnt - b0), 32'd1);
        check("rs_hits", 32'(hit_cnt - h0), 32'd2);
        check("rs_rx_left", 32'(exp_rx.size()), 32'd0);

        // Underflow: empty FIFO on a read
        u0 = unf_cnt; t0 = txr_cnt;
        i2c_start();
        write_byte(8'h4B, ack);
        read_byte(1'b1, d);
        check("unf_byte", 32'(d), 32'h0FF);
        i2c_stop();
        check("unf_pulses", 32'(unf_cnt - u0), 32'd1);
        check("unf_no_tx_ready", 32'(txr_cnt - t0), 32'd0);

        // Overflow: sink not ready
        o0 = ovf_cnt; r0 = rxv_cnt;
        rx_ready = 1'b0;
        i2c_start();
        write_byte(8'h4A, ack);
        check("ovf_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h77, ack);
        check("ovf_nack", 32'(ack), 32'd1);
        i2c_stop();
        rx_ready = 1'b1;
        check("ovf_pulses", 32'(ovf_cnt - o0), 32'd1);
        check("ovf_no_rx", 32'(rxv_cnt - r0), 32'd0);

        // Reset in the middle of a read byte
        fifo.push_back(8'h00);
        tick(3);
        i2c_start();
        write_byte(8'h4B, ack);
        sbit(1'b1, s);
        sbit(1'b1, s);
        sbit(1'b1, s);
        m_sda = 1'b1;
        tick(6);
        check("mid_rd_driving", 32'(sda_oe), 32'd1);
        i2c_rst_n = 1'b0;
        #1;
        check("rst_async_oe", 32'(sda_oe), 32'd0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        tick(2);
        check("rst_mid_busy", 32'(busy), 32'd0);
        i2c_rst_n = 1'b1;
        tick(8);
        fifo.delete();
        fifo.push_back(8'h5A); exp_rd.push_back(8'h5A);
        tick(3);
        h0 = hit_cnt;
        i2c_start();
        write_byte(8'h4B, ack);
        check("post_rst_ack", 32'(ack), 32'd0);
        read_byte(1'b1, d);
        check("post_rst_byte", 32'(d), 32'(exp_rd.pop_front()));
        i2c_stop();
        check("post_rst_hits", 32'(hit_cnt - h0), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        tick(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
